psum_window_acc: RTL and testbench
==================================

PSUM_WINDOW_ACC -- requirements
Module: psum_window_acc

Interface
REQ-001 Parameter DATA_W, default 8, width of one partial sum per channel, unsigned.
REQ-002 Parameter DEPTH, default 3, window length in samples; legal range 2..64.
REQ-003 Parameter CH, default 1, number of independent channels sharing one handshake.
REQ-004 Parameter OUT_W, default DATA_W+$clog2(DEPTH), output width per channel; legal range 1..DATA_W+$clog2(DEPTH).
REQ-005 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 Port rst  input  1  synchronous reset, active-high.
REQ-007 Port en  input  1  accept enable; state is held while low.
REQ-008 Port clear  input  1  synchronous soft clear of window state.
REQ-009 Port mode  input  1  0 = sliding window, 1 = block (tumbling) window.
REQ-010 Port in_valid  input  1  input sample valid.
REQ-011 Port in_ready  output  1  block can accept a sample this cycle.
REQ-012 Port in_data  input  CH*DATA_W  packed samples, channel c in bits [c*DATA_W +: DATA_W].
REQ-013 Port out_valid  output  1  out_data holds a result.
REQ-014 Port out_ready  input  1  consumer accepts the result.
REQ-015 Port out_data  output  CH*OUT_W  packed window sums, channel c in bits [c*OUT_W +: OUT_W].
REQ-016 Port out_sat  output  CH  per-channel flag: current out_data is clamped.
REQ-017 Port fill_count  output  $clog2(DEPTH+1)  number of samples currently in the window.

Function
REQ-018 in_ready SHALL equal en && !clear && (!out_valid || out_ready), combinationally.
REQ-019 A sample SHALL be accepted when in_valid && in_ready; only accepted samples change window state.
REQ-020 Each channel SHALL keep a DEPTH-entry circular buffer and a running sum of width DATA_W+$clog2(DEPTH); all channels share one write pointer.
REQ-021 On accept, each channel SHALL write the new sample at the write pointer and update sum = sum + new - old, where old is the overwritten entry (0 if never written).
REQ-022 The write pointer SHALL advance by 1 on accept and wrap from DEPTH-1 to 0.
REQ-023 Sliding mode: fill_count SHALL increment on accept and saturate at DEPTH; a result SHALL be produced for every accept after which fill_count==DEPTH.
REQ-024 Block mode: a result SHALL be produced on every DEPTH-th accept; in that same cycle, sum, buffer, fill_count and pointer SHALL return to 0.
REQ-025 Latency: out_valid SHALL rise on the cycle after the producing accept, with out_data equal to the full-window sum including that sample.
REQ-026 out_data and out_sat SHALL hold stable while out_valid && !out_ready.
REQ-027 When out_valid && out_ready coincide with a producing accept, the new result SHALL load with no bubble; otherwise out_valid SHALL fall after out_ready.
REQ-028 If a channel's sum exceeds 2^OUT_W-1, that channel SHALL output 2^OUT_W-1 and set its out_sat bit; otherwise out_sat=0. The internal sum SHALL never be clamped.
REQ-029 mode SHALL be sampled only while fill_count==0; changes at other times SHALL be ignored until the window next empties.
REQ-030 clear SHALL zero buffers, sums, pointer, fill_count, out_valid, out_data and out_sat; it has priority over a same-cycle accept, which is dropped.
REQ-031 en low SHALL hold all window state; the output handshake SHALL continue to drain.

Reset
REQ-032 On rst, the block SHALL set out_valid=0, out_data=0, out_sat=0, fill_count=0, pointer=0, all sums and buffers to 0, and the latched mode to 0; rst overrides clear, en and any accept.

Verification (DATA_W=8, DEPTH=3, CH=1, OUT_W=10 unless stated)
REQ-033 Sliding mode, out_ready=1, accept 5,7,9,11 -> no result after 5 or 7; out_data=21 after 9 and 27 after 11, each one cycle after its accept.
REQ-034 Block mode, accept 1..6 -> exactly two results, 6 and 15; fill_count reads 0 after each result.
REQ-035 Result pending with out_ready=0 for 4 cycles while in_valid=1 -> in_ready=0 and out_data stays stable; on out_ready=1, the next accept in the same cycle produces the next result with no bubble.
REQ-036 OUT_W=8, accept 200,200,200 -> out_data=255, out_sat=1; then accept 0 -> out_data=255 (internal 400), out_sat=1; then accept 0 -> out_data=200, out_sat=0.
REQ-037 CH=2, lane0 1,2,3 and lane1 10,20,30 -> out_data lanes 6 and 60; a clear asserted with in_valid=1 drops that sample and sets fill_count=0.
REQ-038 rst asserted mid-window with fill_count=2 and out_valid=1 -> next cycle all outputs are 0, and the following 3 accepts produce a result only on the third.

Source files
------------

// File: rtl/psum_window_acc_if.sv
// Sample-in / window-sum-out handshake bundle for psum_window_acc.
interface psum_window_acc_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CH     = 1,
  parameter int unsigned OUT_W  = 10
);
  logic                  in_valid;
  logic                  in_ready;
  logic [CH*DATA_W-1:0]  in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [CH*OUT_W-1:0]   out_data;
  logic [CH-1:0]         out_sat;

  // Producer of samples / consumer of results.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  // The accumulator itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/psum_window_acc.sv
// Per-channel windowed running sum with sliding or tumbling windows,
// a shared write pointer, a registered output stage and output clamping.
module psum_window_acc #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 3,
  parameter int unsigned CH     = 1,
  parameter int unsigned OUT_W  = DATA_W + $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       clear,
  input  logic                       mode,
  output logic [$clog2(DEPTH+1)-1:0] fill_count,
  psum_window_acc_if.slave           bus
);

  localparam int unsigned SUM_W  = DATA_W + $clog2(DEPTH);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0]    ptr_q;
  logic                mode_q;
  logic [DATA_W-1:0]   buf_q [CH][DEPTH];
  logic [SUM_W-1:0]    sum_q [CH];

  logic [DATA_W-1:0]   sample [CH];
  logic [SUM_W-1:0]    nsum   [CH];
  logic [CH*OUT_W-1:0] res_data;
  logic [CH-1:0]       res_sat;

  logic                accept;
  logic                eff_mode;
  logic                produce;
  logic                block_wrap;
  logic [PTR_W-1:0]    ptr_next;
  logic [FILL_W-1:0]   fill_next;

  // Accept only when enabled, not clearing, and the output slot is free or draining.
  assign bus.in_ready = en && !clear && (!bus.out_valid || bus.out_ready);

  // Per-channel next sum and clamped result.
  for (genvar c = 0; c < CH; c++) begin : g_ch
    assign sample[c] = bus.in_data[c*DATA_W +: DATA_W];
    assign nsum[c]   = sum_q[c] + SUM_W'(sample[c]) - SUM_W'(buf_q[c][ptr_q]);
    if (OUT_W < SUM_W) begin : g_clamp
      assign res_sat[c] = |nsum[c][SUM_W-1:OUT_W];
    end else begin : g_full
      assign res_sat[c] = 1'b0;
    end
    assign res_data[c*OUT_W +: OUT_W] = res_sat[c] ? {OUT_W{1'b1}} : nsum[c][OUT_W-1:0];
  end

  // Accept decode; the live mode applies only while the window is empty.
  always_comb begin
    accept     = bus.in_valid && bus.in_ready;
    eff_mode   = (fill_count == '0) ? mode : mode_q;
    produce    = eff_mode ? (fill_count == FILL_W'(DEPTH-1))
                          : (fill_count >= FILL_W'(DEPTH-1));
    block_wrap = eff_mode && produce;
    ptr_next   = (ptr_q == PTR_W'(DEPTH-1)) ? '0 : ptr_q + PTR_W'(1);
    fill_next  = (fill_count == FILL_W'(DEPTH)) ? fill_count : fill_count + FILL_W'(1);
  end

  // Window mode is captured each cycle the window is empty and frozen otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= 1'b0;
    end else if (fill_count == '0) begin
      mode_q <= mode;
    end
  end

  // Window state and output register.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ptr_q         <= '0;
      fill_count    <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sat   <= '0;
      for (int c = 0; c < CH; c++) begin
        sum_q[c] <= '0;
        for (int d = 0; d < DEPTH; d++) begin
          buf_q[c][d] <= '0;
        end
      end
    end else begin
      if (accept) begin
        if (block_wrap) begin
          ptr_q      <= '0;
          fill_count <= '0;
          for (int c = 0; c < CH; c++) begin
            sum_q[c] <= '0;
            for (int d = 0; d < DEPTH; d++) begin
              buf_q[c][d] <= '0;
            end
          end
        end else begin
          ptr_q      <= ptr_next;
          fill_count <= fill_next;
          for (int c = 0; c < CH; c++) begin
            sum_q[c]        <= nsum[c];
            buf_q[c][ptr_q] <= sample[c];
          end
        end
      end
      if (accept && produce) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= res_data;
        bus.out_sat   <= res_sat;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_psum_window_acc.sv
// Directed bench for psum_window_acc: default, narrow-output and two-channel instances.
module tb_psum_window_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, clear, mode;
  logic [1:0] fca, fcb, fcc;
  int n_checks = 0;
  int n_fail   = 0;

  psum_window_acc_if #(.DATA_W(8), .CH(1), .OUT_W(10)) ifa ();
  psum_window_acc_if #(.DATA_W(8), .CH(1), .OUT_W(8))  ifb ();
  psum_window_acc_if #(.DATA_W(8), .CH(2), .OUT_W(10)) ifc ();

  psum_window_acc #(.DATA_W(8), .DEPTH(3), .CH(1), .OUT_W(10)) dut_a (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .mode(mode), .fill_count(fca), .bus(ifa));
  psum_window_acc #(.DATA_W(8), .DEPTH(3), .CH(1), .OUT_W(8)) dut_b (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .mode(mode), .fill_count(fcb), .bus(ifb));
  psum_window_acc #(.DATA_W(8), .DEPTH(3), .CH(2), .OUT_W(10)) dut_c (
    .clk(clk), .rst(rst), .en(en), .clear(clear), .mode(mode), .fill_count(fcc), .bus(ifc));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; clear = 1'b0; mode = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_data = '0; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.in_data = '0; ifb.out_ready = 1'b1;
    ifc.in_valid = 1'b0; ifc.in_data = '0; ifc.out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_checks++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", ifa.out_valid); end
    n_checks++; if (ifa.out_data !== 10'd0) begin n_fail++; $display("FAIL reset_data: got %0d expected 0", ifa.out_data); end
    n_checks++; if (ifa.out_sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %0b expected 0", ifa.out_sat); end
    n_checks++; if (fca !== 2'd0) begin n_fail++; $display("FAIL reset_fill: got %0d expected 0", fca); end
    n_checks++; if (ifa.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", ifa.in_ready); end
    n_checks++; if (ifc.out_data !== 20'd0) begin n_fail++; $display("FAIL reset_data_ch2: got %0d expected 0", ifc.out_data); end
  endtask

  task automatic test_sliding();
    int   vals [4] = '{5, 7, 9, 11};
    logic expv [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int   expd [4] = '{0, 0, 21, 27};
    mode = 1'b0; ifa.out_ready = 1'b1;
    do_clear();
    for (int i = 0; i < 4; i++) begin
      ifa.in_valid = 1'b1; ifa.in_data = 8'(vals[i]);
      tick();
      n_checks++; if (ifa.out_valid !== expv[i]) begin n_fail++; $display("FAIL slide_valid[%0d]: got %0b expected %0b", i, ifa.out_valid, expv[i]); end
      if (expv[i]) begin
        n_checks++; if (ifa.out_data !== 10'(expd[i])) begin n_fail++; $display("FAIL slide_data[%0d]: got %0d expected %0d", i, ifa.out_data, expd[i]); end
      end
    end
    ifa.in_valid = 1'b0;
    tick();
    n_checks++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL slide_drain: got %0b expected 0", ifa.out_valid); end
    n_checks++; if (fca !== 2'd3) begin n_fail++; $display("FAIL slide_fill_sat: got %0d expected 3", fca); end
  endtask

  task automatic test_block();
    logic expv [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int   expd [10] = '{0, 0, 6, 0, 0, 15, 0, 0, 24, 27};
    int   expf [10] = '{1, 2, 0, 1, 2, 0, 1, 2, 3, 3};
    int   n_res = 0;
    mode = 1'b1; ifa.out_ready = 1'b1;
    do_clear();
    for (int i = 0; i < 10; i++) begin
      // Mode change mid-window must be ignored until the window empties.
      if (i == 4) mode = 1'b0;
      ifa.in_valid = 1'b1; ifa.in_data = 8'(i + 1);
      tick();
      if (i < 6 && ifa.out_valid) n_res++;
      n_checks++; if (ifa.out_valid !== expv[i]) begin n_fail++; $display("FAIL block_valid[%0d]: got %0b expected %0b", i, ifa.out_valid, expv[i]); end
      if (expv[i]) begin
        n_checks++; if (ifa.out_data !== 10'(expd[i])) begin n_fail++; $display("FAIL block_data[%0d]: got %0d expected %0d", i, ifa.out_data, expd[i]); end
      end
      n_checks++; if (fca !== 2'(expf[i])) begin n_fail++; $display("FAIL block_fill[%0d]: got %0d expected %0d", i, fca, expf[i]); end
    end
    ifa.in_valid = 1'b0;
    n_checks++; if (n_res !== 2) begin n_fail++; $display("FAIL block_result_count: got %0d expected 2", n_res); end
    tick();
  endtask

  task automatic test_back_to_back();
    mode = 1'b0; ifa.out_ready = 1'b1;
    do_clear();
    for (int i = 1; i <= 3; i++) begin
      ifa.in_valid = 1'b1; ifa.in_data = 8'(i);
      tick();
    end
    ifa.in_data = 8'd4; ifa.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (ifa.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d]: got %0b expected 0", i, ifa.in_ready); end
      tick();
      n_checks++; if (ifa.out_valid !== 1'b1 || ifa.out_data !== 10'd6) begin n_fail++; $display("FAIL stall_hold[%0d]: got v=%0b d=%0d expected v=1 d=6", i, ifa.out_valid, ifa.out_data); end
    end
    ifa.out_ready = 1'b1;
    #1;
    n_checks++; if (ifa.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %0b expected 1", ifa.in_ready); end
    tick();
    n_checks++; if (ifa.out_valid !== 1'b1 || ifa.out_data !== 10'd9) begin n_fail++; $display("FAIL no_bubble: got v=%0b d=%0d expected v=1 d=9", ifa.out_valid, ifa.out_data); end
    ifa.in_valid = 1'b0;
    tick();
    n_checks++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %0b expected 0", ifa.out_valid); end
  endtask

  task automatic test_enable();
    mode = 1'b0; ifa.out_ready = 1'b0;
    do_clear();
    for (int i = 1; i <= 3; i++) begin
      ifa.in_valid = 1'b1; ifa.in_data = 8'(i);
      tick();
    end
    en = 1'b0; ifa.in_data = 8'd50; ifa.out_ready = 1'b1;
    #1;
    n_checks++; if (ifa.in_ready !== 1'b0) begin n_fail++; $display("FAIL en_low_in_ready: got %0b expected 0", ifa.in_ready); end
    tick();
    n_checks++; if (ifa.out_valid !== 1'b0) begin n_fail++; $display("FAIL en_low_drain: got %0b expected 0", ifa.out_valid); end
    n_checks++; if (fca !== 2'd3) begin n_fail++; $display("FAIL en_low_hold_fill: got %0d expected 3", fca); end
    en = 1'b1; ifa.in_data = 8'd10;
    tick();
    // Window 2,3,10: the sample offered while disabled must not have entered.
    n_checks++; if (ifa.out_valid !== 1'b1 || ifa.out_data !== 10'd15) begin n_fail++; $display("FAIL en_resume: got v=%0b d=%0d expected v=1 d=15", ifa.out_valid, ifa.out_data); end
    ifa.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_saturate();
    logic [7:0] vals [5] = '{8'd200, 8'd200, 8'd200, 8'd0, 8'd0};
    logic [7:0] expd [5] = '{8'd0, 8'd0, 8'd255, 8'd255, 8'd200};
    logic       exps [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    mode = 1'b0; ifb.out_ready = 1'b1;
    do_clear();
    for (int i = 0; i < 5; i++) begin
      ifb.in_valid = 1'b1; ifb.in_data = vals[i];
      tick();
      if (i >= 2) begin
        n_checks++; if (ifb.out_valid !== 1'b1 || ifb.out_data !== expd[i] || ifb.out_sat !== exps[i]) begin
          n_fail++; $display("FAIL sat[%0d]: got v=%0b d=%0d s=%0b expected v=1 d=%0d s=%0b", i, ifb.out_valid, ifb.out_data, ifb.out_sat, expd[i], exps[i]);
        end
      end
    end
    ifb.in_valid = 1'b0;
    tick();
  endtask

  task automatic test_multichannel();
    mode = 1'b0; ifc.out_ready = 1'b1;
    do_clear();
    for (int i = 1; i <= 3; i++) begin
      ifc.in_valid = 1'b1; ifc.in_data = {8'(10 * i), 8'(i)};
      tick();
    end
    n_checks++; if (ifc.out_valid !== 1'b1 || ifc.out_data !== {10'd60, 10'd6}) begin n_fail++; $display("FAIL ch2_sum: got v=%0b d=%h expected v=1 d=%h", ifc.out_valid, ifc.out_data, {10'd60, 10'd6}); end
    ifc.in_data = {8'd7, 8'd7}; clear = 1'b1;
    #1;
    n_checks++; if (ifc.in_ready !== 1'b0) begin n_fail++; $display("FAIL clear_in_ready: got %0b expected 0", ifc.in_ready); end
    tick();
    clear = 1'b0; ifc.in_valid = 1'b0;
    n_checks++; if (fcc !== 2'd0) begin n_fail++; $display("FAIL clear_fill: got %0d expected 0", fcc); end
    n_checks++; if (ifc.out_valid !== 1'b0 || ifc.out_data !== 20'd0 || ifc.out_sat !== 2'd0) begin n_fail++; $display("FAIL clear_out: got v=%0b d=%0d s=%0d expected 0", ifc.out_valid, ifc.out_data, ifc.out_sat); end
    ifc.in_valid = 1'b1; ifc.in_data = {8'd1, 8'd2};
    tick();
    ifc.in_valid = 1'b0;
    n_checks++; if (fcc !== 2'd1) begin n_fail++; $display("FAIL clear_refill: got %0d expected 1", fcc); end
    tick();
  endtask

  task automatic test_reset_midwindow();
    mode = 1'b0; ifa.out_ready = 1'b1;
    do_clear();
    for (int i = 1; i <= 3; i++) begin
      ifa.in_valid = 1'b1; ifa.in_data = 8'(i);
      tick();
    end
    ifa.out_ready = 1'b0; ifa.in_data = 8'd9; rst = 1'b1;
    tick();
    rst = 1'b0; ifa.out_ready = 1'b1;
    n_checks++; if (ifa.out_valid !== 1'b0 || ifa.out_data !== 10'd0 || ifa.out_sat !== 1'b0 || fca !== 2'd0) begin
      n_fail++; $display("FAIL rst_mid: got v=%0b d=%0d s=%0b f=%0d expected all 0", ifa.out_valid, ifa.out_data, ifa.out_sat, fca);
    end
    for (int i = 4; i <= 6; i++) begin
      ifa.in_data = 8'(i);
      tick();
      n_checks++; if (ifa.out_valid !== (i == 6)) begin n_fail++; $display("FAIL rst_refill_valid[%0d]: got %0b expected %0b", i, ifa.out_valid, (i == 6)); end
    end
    n_checks++; if (ifa.out_data !== 10'd15) begin n_fail++; $display("FAIL rst_refill_data: got %0d expected 15", ifa.out_data); end
    ifa.in_valid = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sliding();
    test_block();
    test_back_to_back();
    test_enable();
    test_saturate();
    test_multichannel();
    test_reset_midwindow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
